// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory stage
package mem_stage_pkg;
  localparam int DATA_W        = 32;
  localparam int REG_W         = 4;
  localparam int DEF_BASE_ADDR = 1024;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;
endpackage

// File: rtl/mem_stage_data_mem.sv
// rtl/mem_stage_data_mem.sv - word-addressed data memory, sync write, comb read
module data_mem
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage with multi-cycle data memory and freeze stall
// Optional MEM_RANGE_CHK_EN adds the addr_err output.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int LATENCY   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN,
  input  logic              MEM_R,
  input  logic              MEM_W,
  input  logic [DATA_W-1:0] ALU_res,
  input  logic [DATA_W-1:0] val_rm,
  input  logic [REG_W-1:0]  dest,
  output logic              freeze,
  output logic              WB_EN_out,
  output logic              MEM_R_out,
  output logic [DATA_W-1:0] ALU_res_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic [REG_W-1:0]  dest_out
`ifdef MEM_RANGE_CHK_EN
  ,
  output logic              addr_err
`endif
);
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit MULTI = (LATENCY > 1);
  localparam logic [DATA_W-1:0] BASE = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W:0]   SPAN = (DATA_W + 1)'(4 * DEPTH);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  offset;
  logic [DATA_W-1:0]  rdata;
  logic [AW-1:0]      word_idx;
  logic               in_range;
  logic               mem_req;
  logic               we;

  assign offset   = ALU_res - BASE;
  assign in_range = (ALU_res >= BASE) && ({1'b0, offset} < SPAN);
  assign word_idx = offset[AW+1:2];
  assign mem_req  = MEM_R | MEM_W;

  // Stall from the request cycle until the final access cycle, which is freeze-low.
  always_comb begin
    freeze = 1'b0;
    if (state == IDLE) freeze = mem_req && MULTI;
    else               freeze = (cnt != '0);
  end

  assign we = MEM_W && in_range && !freeze && !rst;

  data_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_data_mem (
    .clk  (clk),
    .we   (we),
    .idx  (word_idx),
    .wdata(val_rm),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      WB_EN_out    <= 1'b0;
      MEM_R_out    <= 1'b0;
      ALU_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
`ifdef MEM_RANGE_CHK_EN
      addr_err     <= 1'b0;
`endif
    end else if (freeze) begin
      if (state == IDLE) begin
        state <= ACCESS;
        cnt   <= CNT_W'(LATENCY - 2);
      end else begin
        cnt <= cnt - 1'b1;
      end
    end else begin
      state        <= IDLE;
      cnt          <= '0;
      WB_EN_out    <= WB_EN;
      MEM_R_out    <= MEM_R;
      ALU_res_out  <= ALU_res;
      mem_data_out <= (MEM_R && in_range) ? rdata : '0;
      dest_out     <= dest;
`ifdef MEM_RANGE_CHK_EN
      addr_err     <= mem_req && !in_range;
`endif
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage
module tb_mem_stage;
  localparam int LAT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        WB_EN, MEM_R, MEM_W;
  logic [31:0] ALU_res, val_rm;
  logic [3:0]  dest;
  logic        freeze, WB_EN_out, MEM_R_out;
  logic [31:0] ALU_res_out, mem_data_out;
  logic [3:0]  dest_out;

  logic        WB_EN_1, MEM_R_1, MEM_W_1;
  logic [31:0] ALU_res_1, val_rm_1;
  logic [3:0]  dest_1;
  logic        freeze_1, WB_EN_out_1, MEM_R_out_1;
  logic [31:0] ALU_res_out_1, mem_data_out_1;
  logic [3:0]  dest_out_1;
`ifdef MEM_RANGE_CHK_EN
  logic        addr_err, addr_err_1;
`endif

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R(MEM_R), .MEM_W(MEM_W),
    .ALU_res(ALU_res), .val_rm(val_rm), .dest(dest), .freeze(freeze),
    .WB_EN_out(WB_EN_out), .MEM_R_out(MEM_R_out), .ALU_res_out(ALU_res_out),
    .mem_data_out(mem_data_out), .dest_out(dest_out)
`ifdef MEM_RANGE_CHK_EN
    , .addr_err(addr_err)
`endif
  );

  mem_stage #(.DEPTH(64), .BASE_ADDR(1024), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .WB_EN(WB_EN_1), .MEM_R(MEM_R_1), .MEM_W(MEM_W_1),
    .ALU_res(ALU_res_1), .val_rm(val_rm_1), .dest(dest_1), .freeze(freeze_1),
    .WB_EN_out(WB_EN_out_1), .MEM_R_out(MEM_R_out_1), .ALU_res_out(ALU_res_out_1),
    .mem_data_out(mem_data_out_1), .dest_out(dest_out_1)
`ifdef MEM_RANGE_CHK_EN
    , .addr_err(addr_err_1)
`endif
  );

  logic [69:0] obs, obs1;
  assign obs  = {WB_EN_out, MEM_R_out, dest_out, ALU_res_out, mem_data_out};
  assign obs1 = {WB_EN_out_1, MEM_R_out_1, dest_out_1, ALU_res_out_1, mem_data_out_1};

  int passed = 0;
  int total  = 0;
  logic [31:0] ref_mem [int];

  // Reference: a byte address maps to a word if it lies in [1024, 1024+256).
  function automatic logic [69:0] ref_op(bit wb, bit r, bit w, logic [31:0] a,
                                         logic [31:0] v, logic [3:0] d);
    bit          inr = (a >= 32'd1024) && (a < 32'd1280);
    int          idx = 0;
    logic [31:0] ld  = 32'h0;
    if (inr) idx = int'((a - 32'd1024) / 4);
    if (inr && w) ref_mem[idx] = v;
    if (inr && r && ref_mem.exists(idx)) ld = ref_mem[idx];
    return {wb, r, d, a, ld};
  endfunction

  task automatic drive_op(input bit wb, input bit r, input bit w, input logic [31:0] a,
                          input logic [31:0] v, input logic [3:0] d,
                          output int fcnt, output bit held);
    logic [69:0] snap;
    @(negedge clk);
    WB_EN = wb; MEM_R = r; MEM_W = w; ALU_res = a; val_rm = v; dest = d;
    snap = obs; fcnt = 0; held = 1'b1;
    #1;
    while (freeze && fcnt <= 20) begin
      fcnt++;
      if (obs !== snap) held = 1'b0;
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    {WB_EN, MEM_R, MEM_W, ALU_res, val_rm, dest} = '0;
    {WB_EN_1, MEM_R_1, MEM_W_1, ALU_res_1, val_rm_1, dest_1} = '0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (obs !== 70'h0) $display("FAIL reset_outputs: got %h expected 0", obs);
    else passed++;
    total++;
    if (freeze !== 1'b0) $display("FAIL reset_freeze: got %b expected 0", freeze);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nonmem();
    int fc; bit h; logic [69:0] e;
    e = ref_op(1, 0, 0, 32'h55, 32'h0, 4'd3);
    drive_op(1, 0, 0, 32'h55, 32'h0, 4'd3, fc, h);
    total++;
    if (fc !== 0) $display("FAIL nonmem_freeze: got %0d cycles expected 0", fc);
    else passed++;
    total++;
    if (obs !== e) $display("FAIL nonmem_out: got %h expected %h", obs, e);
    else passed++;
  endtask

  task automatic test_store_load();
    int fc; bit h; logic [69:0] e;
    logic [31:0] addrs [3] = '{32'd1028, 32'd1028, 32'd1030};
    for (int i = 0; i < 3; i++) begin
      bit st = (i == 0);
      e = ref_op(0, !st, st, addrs[i], 32'hDEAD_BEEF, 4'd7);
      drive_op(0, !st, st, addrs[i], 32'hDEAD_BEEF, 4'd7, fc, h);
      total++;
      if (fc !== LAT - 1) $display("FAIL sl_freeze[%0d]: got %0d expected %0d", i, fc, LAT - 1);
      else passed++;
      total++;
      if (!h) $display("FAIL sl_hold[%0d]: outputs changed while frozen", i);
      else passed++;
      total++;
      if (obs !== e) $display("FAIL sl_out[%0d]: got %h expected %h", i, obs, e);
      else passed++;
    end
  endtask

  task automatic test_out_of_range();
    int fc; bit h; logic [69:0] e;
    for (int i = 0; i < 3; i++) begin
      bit st = (i == 0);
      bit nm = (i == 2);
      e = ref_op(nm, i == 1, st, nm ? 32'd1024 : 32'h10, 32'h0BAD_F00D, 4'd2);
      drive_op(nm, i == 1, st, nm ? 32'd1024 : 32'h10, 32'h0BAD_F00D, 4'd2, fc, h);
      total++;
      if (obs !== e) $display("FAIL oor_out[%0d]: got %h expected %h", i, obs, e);
      else passed++;
`ifdef MEM_RANGE_CHK_EN
      total++;
      if (addr_err !== !nm) $display("FAIL oor_addr_err[%0d]: got %b expected %b", i, addr_err, !nm);
      else passed++;
`endif
    end
  endtask

  task automatic test_reset_abort();
    int fc; bit h; logic [69:0] e;
    e = ref_op(0, 0, 1, 32'd1032, 32'h0000_CAFE, 4'd1);
    drive_op(0, 0, 1, 32'd1032, 32'h0000_CAFE, 4'd1, fc, h);
    @(negedge clk);
    MEM_W = 1'b1; MEM_R = 1'b0; WB_EN = 1'b0; ALU_res = 32'd1032; val_rm = 32'h1234;
    #1;
    total++;
    if (freeze !== 1'b1) $display("FAIL abort_freeze_start: got %b expected 1", freeze);
    else passed++;
    @(negedge clk);
    rst = 1'b1;
    {WB_EN, MEM_R, MEM_W, ALU_res, val_rm, dest} = '0;
    @(posedge clk); #1;
    total++;
    if (freeze !== 1'b0) $display("FAIL abort_freeze_end: got %b expected 0", freeze);
    else passed++;
    total++;
    if (obs !== 70'h0) $display("FAIL abort_outputs: got %h expected 0", obs);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    e = ref_op(1, 1, 0, 32'd1032, 32'h0, 4'd9);
    drive_op(1, 1, 0, 32'd1032, 32'h0, 4'd9, fc, h);
    total++;
    if (obs !== e) $display("FAIL abort_reload: got %h expected %h", obs, e);
    else passed++;
  endtask

  task automatic test_random();
    int fc; bit h; logic [69:0] e;
    int words [4] = '{0, 5, 17, 63};
    for (int n = 0; n < 40; n++) begin
      int kind = $urandom_range(0, 2);
      int slot = $urandom_range(0, 5);
      logic [31:0] a, v;
      bit r, w, wb;
      logic [3:0] d;
      if (slot < 4) a = 32'd1024 + 32'(words[slot] * 4) + 32'($urandom_range(0, 3));
      else if (slot == 4) a = 32'd1280 + 32'($urandom_range(0, 64));
      else a = 32'($urandom_range(0, 1023));
      v = $urandom;
      d = 4'($urandom_range(0, 15));
      r = (kind == 1);
      w = (kind == 2);
      if (r && slot < 4 && !ref_mem.exists(words[slot])) begin
        r = 1'b0; w = 1'b1;
      end
      wb = w ? 1'b0 : 1'($urandom_range(0, 1));
      e = ref_op(wb, r, w, a, v, d);
      drive_op(wb, r, w, a, v, d, fc, h);
      total++;
      if (fc !== ((r || w) ? LAT - 1 : 0))
        $display("FAIL rand_freeze[%0d]: got %0d expected %0d", n, fc, (r || w) ? LAT - 1 : 0);
      else passed++;
      total++;
      if (obs !== e) $display("FAIL rand_out[%0d]: got %h expected %h", n, obs, e);
      else passed++;
    end
  endtask

  task automatic test_latency1();
    logic [31:0] vals [2];
    vals[0] = $urandom;
    vals[1] = $urandom;
    for (int i = 0; i < 4; i++) begin
      bit          st = (i % 2 == 0);
      logic [31:0] v  = vals[i / 2];
      logic [69:0] e  = {1'b0, !st, 4'd5, 32'd1024, st ? 32'h0 : v};
      @(negedge clk);
      WB_EN_1 = 1'b0; MEM_R_1 = !st; MEM_W_1 = st; ALU_res_1 = 32'd1024;
      val_rm_1 = v; dest_1 = 4'd5;
      #1;
      total++;
      if (freeze_1 !== 1'b0) $display("FAIL lat1_freeze[%0d]: got %b expected 0", i, freeze_1);
      else passed++;
      @(posedge clk); #1;
      total++;
      if (obs1 !== e) $display("FAIL lat1_out[%0d]: got %h expected %h", i, obs1, e);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_store_load();
    test_out_of_range();
    test_reset_abort();
    test_random();
    test_latency1();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the execute-stage outputs in the 5-stage ARM pipeline: takes WB_EN/MEM_R/MEM_W, ALU_res (address or result), val_rm (store data) and dest.
- Performs data-memory loads and stores against an internal multi-cycle data memory and raises freeze to stall upstream stages while an access is in flight.
- Registers the result into the MEM/WB boundary for the write-back stage.

Parameters:
- DEPTH, 64, number of 32-bit words in data memory.
- BASE_ADDR, 1024, byte address mapped to word 0.
- LATENCY, 4, access cycles per load/store (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- WB_EN  input  1  write-back enable from execute.
- MEM_R  input  1  load request.
- MEM_W  input  1  store request; MEM_R and MEM_W are never both 1.
- ALU_res  input  32  byte address for load/store, else ALU result.
- val_rm  input  32  store data.
- dest  input  4  destination register.
- freeze  output  1  stall request to upstream stages; combinational.
- WB_EN_out  output  1  registered WB_EN.
- MEM_R_out  output  1  registered MEM_R (write-back result select).
- ALU_res_out  output  32  registered ALU_res.
- mem_data_out  output  32  registered load data.
- dest_out  output  4  registered dest.

Behaviour:
- Reset: all registered outputs 0, freeze 0, FSM in IDLE, counter 0. Memory contents are not cleared.
- Word index = (ALU_res - BASE_ADDR) >> 2; bits [1:0] ignored. In range when BASE_ADDR <= ALU_res < BASE_ADDR + 4*DEPTH.
- Out-of-range load returns 0. Out-of-range store is dropped.
- Non-memory op (MEM_R=MEM_W=0), state IDLE: freeze=0; inputs registered to outputs at the next edge (1-cycle latency); mem_data_out=0.
- FSM states: IDLE, ACCESS.
- LATENCY==1: load/store completes like a non-memory op. No freeze; store is written and load data is registered at the next edge.
- LATENCY>1, request in IDLE at cycle t:
  - freeze=1 combinationally in cycle t; next state ACCESS with cnt=LATENCY-2.
  - In ACCESS with cnt!=0: freeze=1, cnt decrements.
  - In ACCESS with cnt==0 (cycle t+LATENCY-1): freeze=0. At that edge the store is committed or load data is captured into mem_data_out, all outputs register, and state returns to IDLE.
- Result: freeze is high for exactly LATENCY-1 cycles; the op leaves the stage LATENCY cycles after arrival.
- While freeze=1 the registered outputs hold their previous values; they are not updated with a bubble. Upstream holds the inputs stable.
- Back-to-back memory ops: the next op is seen in IDLE on the cycle after completion and freezes again. There is no idle gap in freeze-low cycles beyond the completing cycle.
- Store: MEM_R_out=0. WB_EN_out is passed through as given (execute sets it 0).
- Load-after-store to the same word returns the stored value.
- rst during ACCESS: the pending store is not performed, the load is discarded, and the FSM goes to IDLE.

Optional Feature:
- MEM_RANGE_CHK_EN defined: adds output addr_err (1 bit, reset 0). It registers 1 for one cycle together with the outputs of any out-of-range load or store, and 0 otherwise.
- Not defined: no addr_err port; out-of-range behaviour is unchanged (load 0, store dropped).

Decomposition:
- Shared package: FSM state typedef (IDLE, ACCESS), DATA_W=32, REG_W=4, default BASE_ADDR constant.
- One sub-module, data_mem: word array of DEPTH entries with a synchronous write enable and a combinational read by index. mem_stage owns address decode, range check, FSM and output registers.

Test Plan:
- Reset, then non-memory op: ALU_res=0x0000_0055, WB_EN=1, dest=3 -> next edge ALU_res_out=0x55, WB_EN_out=1, dest_out=3, freeze never 1.
- Store val_rm=0xDEAD_BEEF to ALU_res=1028 with LATENCY=4 -> freeze high exactly 3 cycles. Then load from 1028 -> mem_data_out=0xDEADBEEF, MEM_R_out=1, after freeze 3 cycles.
- Load from 1030 (misaligned) after the store above -> 0xDEADBEEF.
- Out-of-range store to 0x0000_0010, then load from it -> mem_data_out=0. With MEM_RANGE_CHK_EN, addr_err pulses once for each op.
- Assert rst in the 2nd freeze cycle of a store 0x1234 to 1032 -> freeze 0 next cycle, outputs 0. A later load from 1032 returns the prior content (0 if never written).
- LATENCY=1 build: store then load back-to-back to 1024 -> freeze never asserted, load returns the stored data on consecutive cycles.
